// File: rtl/ex.sv
// Execute stage: single-cycle ADD/ADDI/SUB plus iterative RV32M unit.
// Registered write-back to regs; hold_o stalls id_ex while the M unit runs.
module ex #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] inst_i,
   input  logic [XLEN-1:0] inst_addr_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            reg_wen_i,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_wen_o,
   output logic            hold_o
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   op1_q, op1_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              wen_q, wen_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic              dz_q, dz_d;
   logic              rd_wen_q, rd_wen_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]   rd_data_q, rd_data_d;

   logic [6:0]        opc;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic              is_alu, is_m, wr_ok, sa, sb;
   logic [XLEN-1:0]   alu_res, mag1, mag2;
   logic [XLEN:0]     sum, rt, rn;
   logic              ge;
   logic [2*XLEN:0]   sh;
   logic [2*XLEN-1:0] nxt, prod;
   logic [XLEN-1:0]   quo, rem, m_res;
   logic              unused_ok;

   assign unused_ok = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

   always_comb begin
      opc     = inst_i[6:0];
      f3      = inst_i[14:12];
      f7      = inst_i[31:25];
      is_m    = (opc == 7'b0110011) && (f7 == 7'b0000001);
      is_alu  = 1'b0;
      alu_res = '0;
      unique case (1'b1)
         (opc == 7'b0010011) && (f3 == 3'b000): begin
            is_alu  = 1'b1;
            alu_res = op1_i + op2_i;
         end
         (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000): begin
            is_alu  = 1'b1;
            alu_res = op1_i + op2_i;
         end
         (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0100000): begin
            is_alu  = 1'b1;
            alu_res = op1_i - op2_i;
         end
         default: ;
      endcase
      wr_ok = reg_wen_i && (rd_addr_i != 5'd0);
      // signed operands: MULH/MULHSU/DIV/REM for op1, MULH/DIV/REM for op2
      sa   = op1_i[XLEN-1] &&
             (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110);
      sb   = op2_i[XLEN-1] &&
             (f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
      mag1 = sa ? -op1_i : op1_i;
      mag2 = sb ? -op2_i : op2_i;
   end

   always_comb begin
      // one radix-2 step of shift-add or restoring shift-subtract
      sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
            (acc_q[0] ? {1'b0, opnd_q} : '0);
      sh  = {acc_q, 1'b0};
      rt  = sh[2*XLEN:XLEN];
      ge  = rt >= {1'b0, opnd_q};
      rn  = ge ? rt - {1'b0, opnd_q} : rt;
      if (f3_q[2])
         nxt = {rn[XLEN-1:0], sh[XLEN-1:1], ge};
      else
         nxt = {sum, acc_q[XLEN-1:1]};
      prod = (sa_q ^ sb_q) ? -nxt : nxt;
      quo  = nxt[XLEN-1:0];
      rem  = nxt[2*XLEN-1:XLEN];
      if (dz_q) begin
         quo = '1;
         rem = op1_q;
      end else begin
         if (sa_q ^ sb_q) quo = -quo;
         if (sa_q) rem = -rem;
      end
      if (f3_q[2])
         m_res = f3_q[1] ? rem : quo;
      else
         m_res = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      op1_d     = op1_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      wen_d     = wen_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dz_d      = dz_q;
      rd_wen_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      unique case (state_q)
         IDLE: begin
            if (is_alu) begin
               rd_wen_d  = wr_ok;
               rd_addr_d = rd_addr_i;
               rd_data_d = alu_res;
            end else if (is_m) begin
               state_d = BUSY;
               cnt_d   = '0;
               acc_d   = {{XLEN{1'b0}}, f3[2] ? mag1 : mag2};
               opnd_d  = f3[2] ? mag2 : mag1;
               op1_d   = op1_i;
               f3_d    = f3;
               rd_d    = rd_addr_i;
               wen_d   = wr_ok;
               sa_d    = sa;
               sb_d    = sb;
               dz_d    = op2_i == '0;
            end
         end
         BUSY: begin
            acc_d = nxt;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d   = IDLE;
               cnt_d     = '0;
               rd_wen_d  = wen_q;
               rd_addr_d = rd_q;
               rd_data_d = m_res;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         op1_q     <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         wen_q     <= 1'b0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         dz_q      <= 1'b0;
         rd_wen_q  <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         op1_q     <= op1_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         dz_q      <= dz_d;
         rd_wen_q  <= rd_wen_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign hold_o    = ((state_q == IDLE) && is_m) ||
                      ((state_q == BUSY) && (cnt_q != 5'd31));
   assign rd_wen_o  = rd_wen_q;
   assign rd_addr_o = rd_addr_q;
   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_ex.sv
// Bench for ex: id_ex-style driver, reference model and result scoreboard.
module tb_ex;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
   logic [4:0]  rd_addr_i;
   logic        reg_wen_i;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic        rd_wen_o, hold_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        w;
      logic [4:0]  rd;
      logic [31:0] d;
      int          hold;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   ex #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .inst_i(inst_i),
      .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
      .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
      .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
      .rd_wen_o(rd_wen_o), .hold_o(hold_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] r_op(input logic [6:0] f7,
                                        input logic [2:0] f3);
      return {f7, 10'd0, f3, 5'd1, 7'b0110011};
   endfunction

   localparam logic [31:0] ADDI = 32'h00000013;

   function automatic void model(input logic [31:0] inst, a, b,
                                 input logic [4:0] rd, input logic wen,
                                 output exp_t e);
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [63:0] sx_a, sx_b, zx_a, zx_b, p;
      int          ia, ib;
      logic        ok;
      opc  = inst[6:0];
      f3   = inst[14:12];
      f7   = inst[31:25];
      sx_a = {{32{a[31]}}, a};
      sx_b = {{32{b[31]}}, b};
      zx_a = {32'd0, a};
      zx_b = {32'd0, b};
      ia   = a;
      ib   = b;
      ok   = 1'b1;
      e.d    = 32'd0;
      e.hold = 0;
      e.lat  = 1;
      if (opc == 7'b0010011 && f3 == 3'b000)
         e.d = a + b;
      else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'h00)
         e.d = a + b;
      else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'h20)
         e.d = a - b;
      else if (opc == 7'b0110011 && f7 == 7'h01) begin
         e.hold = 32;
         e.lat  = 33;
         case (f3)
            3'd0: begin p = zx_a * zx_b; e.d = p[31:0]; end
            3'd1: begin p = sx_a * sx_b; e.d = p[63:32]; end
            3'd2: begin p = sx_a * zx_b; e.d = p[63:32]; end
            3'd3: begin p = zx_a * zx_b; e.d = p[63:32]; end
            3'd4: e.d = (b == 0) ? 32'hFFFFFFFF :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ?
                        32'h80000000 : 32'(ia / ib);
            3'd5: e.d = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: e.d = (b == 0) ? a :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ?
                        32'd0 : 32'(ia % ib);
            default: e.d = (b == 0) ? a : a % b;
         endcase
      end else
         ok = 1'b0;
      e.w  = ok && wen && (rd != 5'd0);
      e.rd = rd;
   endfunction

   // Present one instruction and hold it until the stage accepts it.
   task automatic issue(input logic [31:0] inst, a, b,
                        input logic [4:0] rd, input logic wen,
                        input bit scramble);
      exp_t e;
      logic h;
      int   hc = 0;
      int   lat = 0;
      bit   done = 0;
      model(inst, a, b, rd, wen, e);
      sb_q.push_back(e);
      inst_i    = inst;
      op1_i     = a;
      op2_i     = b;
      rd_addr_i = rd;
      reg_wen_i = wen;
      inst_addr_i = inst_addr_i + 32'd4;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         h = hold_o;
         if (h) hc++;
         @(posedge clk);
         #1;
         lat++;
         if (!h) done = 1;
         else begin
            chk("busy_wen", {31'd0, rd_wen_o}, 32'd0);
            if (scramble) begin
               op1_i     = $urandom;
               op2_i     = $urandom;
               rd_addr_i = 5'($urandom);
            end
         end
      end
      chk("accepted", {31'd0, done}, 32'd1);
      e = sb_q.pop_front();
      chk("wen", {31'd0, rd_wen_o}, {31'd0, e.w});
      if (e.w) begin
         chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
         chk("rd_data", rd_data_o, e.d);
      end
      chk("hold_cycles", hc, e.hold);
      chk("latency", lat, e.lat);
   endtask

   initial begin
      rst_n       = 1'b0;
      inst_i      = ADDI;
      inst_addr_i = 32'd0;
      op1_i       = '0;
      op2_i       = '0;
      rd_addr_i   = '0;
      reg_wen_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wen", {31'd0, rd_wen_o}, 32'd0);
      chk("rst_addr", {27'd0, rd_addr_o}, 32'd0);
      chk("rst_data", rd_data_o, 32'd0);
      chk("rst_hold", {31'd0, hold_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(ADDI, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1, 0);
      issue(r_op(7'h20, 3'd0), 32'd0, 32'd1, 5'd6, 1'b1, 0);
      issue(ADDI, 32'd5, 32'd6, 5'd0, 1'b1, 0);
      issue(r_op(7'h00, 3'd0), 32'h12345678, 32'h11111111, 5'd7, 1'b1, 0);

      for (int f = 0; f < 4; f++)
         issue(r_op(7'h01, 3'(f)), 32'hFFFFFFFF, 32'd2, 5'(8 + f), 1'b1, 0);

      issue(r_op(7'h01, 3'd4), 32'hFFFFFFF9, 32'd2, 5'd12, 1'b1, 0);
      issue(r_op(7'h01, 3'd6), 32'hFFFFFFF9, 32'd2, 5'd13, 1'b1, 0);
      issue(r_op(7'h01, 3'd5), 32'h0000ABCD, 32'd0, 5'd14, 1'b1, 0);
      issue(r_op(7'h01, 3'd7), 32'd5, 32'd0, 5'd15, 1'b1, 0);
      issue(r_op(7'h01, 3'd4), 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b1, 0);
      issue(r_op(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 5'd17, 1'b1, 0);
      issue(r_op(7'h01, 3'd4), 32'd9, 32'd0, 5'd18, 1'b1, 0);
      issue(r_op(7'h01, 3'd6), 32'hFFFFFFF7, 32'd0, 5'd19, 1'b1, 0);

      // back-to-back with operands disturbed while busy
      issue(r_op(7'h01, 3'd0), 32'h00001234, 32'h00005678, 5'd20, 1'b1, 1);
      issue(r_op(7'h00, 3'd0), 32'd100, 32'd23, 5'd21, 1'b1, 0);
      issue(r_op(7'h01, 3'd4), 32'hFFFF0000, 32'd7, 5'd22, 1'b1, 1);

      issue(32'h00000073, 32'd1, 32'd2, 5'd3, 1'b1, 0);
      issue(r_op(7'h01, 3'd0), 32'd3, 32'd4, 5'd9, 1'b0, 0);

      for (int i = 0; i < 6; i++)
         issue(r_op(7'h01, 3'($urandom_range(0, 7))), $urandom, $urandom,
               5'($urandom_range(1, 31)), 1'b1, 0);

      // reset in the middle of a DIVU
      inst_i    = r_op(7'h01, 3'd5);
      op1_i     = 32'd1000;
      op2_i     = 32'd7;
      rd_addr_i = 5'd23;
      reg_wen_i = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      inst_i = ADDI;
      rd_addr_i = 5'd0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_wen", {31'd0, rd_wen_o}, 32'd0);
      chk("mid_rst_data", rd_data_o, 32'd0);
      chk("mid_rst_hold", {31'd0, hold_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         chk("post_rst_wen", {31'd0, rd_wen_o}, 32'd0);
      end
      issue(ADDI, 32'd40, 32'd2, 5'd24, 1'b1, 0);
      issue(r_op(7'h01, 3'd5), 32'd1000, 32'd7, 5'd25, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/ex.md
# ex

Execute stage: the consumer of the decode stage's `id_ex` operand bundle. It computes single-cycle integer results for ADDI/ADD/SUB and drives registered write-back to `regs`. It also runs an iterative 32-cycle multiply/divide unit for the RV32M ops, stalling the front end through `hold_o`. It sits between the `id_ex` pipeline register and the `regs` write port.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk  in  1`: single clock; all state is updated on the rising edge.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `inst_i  in  32`: instruction from `id_ex`.
- `inst_addr_i  in  32`: instruction address, carried for debug only.
- `op1_i  in  32`: operand 1, rs1 data.
- `op2_i  in  32`: operand 2, either rs2 data or the sign-extended I-immediate.
- `rd_addr_i  in  5`: destination register.
- `reg_wen_i  in  1`: write request from decode.
- `rd_addr_o  out  5`: write-back address to `regs`.
- `rd_data_o  out  32`: write-back data.
- `rd_wen_o  out  1`: write-back enable; high for exactly one cycle per retired writing instruction.
- `hold_o  out  1`: stall request. While it is high, `id_ex` and earlier stages hold their contents.

## Operation
- Decode uses `opcode=inst_i[6:0]`, `funct3=inst_i[14:12]` and `funct7=inst_i[31:25]`.
- Single-cycle ops:
  - ADDI (0010011/000): `op1+op2`.
  - ADD (0110011/000/0000000): `op1+op2`.
  - SUB (0110011/000/0100000): `op1-op2`.
  - All results wrap modulo 2^32.
- M ops (opcode 0110011, funct7 0000001), selected by funct3:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed×unsigned.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Division follows RV32M semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = op1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- The M unit works on magnitudes with a radix-2 shift-add (multiply) or restoring shift-subtract (divide), one step per cycle, 32 steps. The sign is corrected on the final step.
- Special cases (divide by zero, overflow) produce the result in the same 33-cycle slot. Latency is constant and never data-dependent.
- Write suppression: `rd_wen_o` is 0 if `reg_wen_i=0`, if `rd_addr_i=0`, or if the instruction is any other encoding. Unsupported encodings retire in one cycle with no write.
- State machine:
  - IDLE: a single-cycle op loads the output registers. A valid M op latches op1, op2, rd and funct3, clears the counter and goes to BUSY.
  - BUSY: one step per cycle, counter increments. At counter=31 the final step is done, the result and write-back are loaded into the output registers, and the FSM returns to IDLE.
- `hold_o` is combinational: (IDLE and M op decoded) or (BUSY and counter≠31).
- Operands, rd and funct3 are captured at start. Changes on the inputs during BUSY are ignored.

## Timing
- Reset (asynchronous, at any time including mid-BUSY):
  - FSM goes to IDLE, counter = 0.
  - `rd_wen_o=0`, `rd_addr_o=0`, `rd_data_o=0`.
  - `hold_o=0`, except the combinational term if an M op is already present at release.
  - A partial M result is discarded and never written.
- Single-cycle op presented in cycle N with no hold: write-back is valid in cycle N+1 for one cycle. Back-to-back ops retire one per cycle.
- M op presented in cycle N:
  - `hold_o` is high in cycles N..N+31 (32 cycles) and low in N+32.
  - `id_ex` advances at the end of N+32.
  - Write-back is valid in cycle N+33.
  - The next instruction is presented in N+33 and may itself start an M op. `hold_o` then rises again in N+33.
- `rd_wen_o` is a one-cycle pulse. Outputs return to `rd_wen_o=0` in the following cycle unless another instruction retires.
- The M op is not restarted in cycle N+32, because the FSM is BUSY in that cycle.
- Result-register zeroing with `rd_wen_o=0` is sufficient for a non-write cycle. `rd_data_o` may hold its previous value when `rd_wen_o=0`.

## Test plan
- Reset: with `rst_n=0`, all outputs are 0. Assert `rst_n=0` in cycle 10 of a DIVU; the FSM is IDLE immediately, no write occurs, and the next op retires normally.
- ADDI x5 = 0x7FFFFFFF + 1: in N+1, `rd_wen_o=1`, `rd_addr_o=5`, `rd_data_o=0x80000000`. SUB with op1=0, op2=1 gives 0xFFFFFFFF. ADDI with rd=x0 gives `rd_wen_o=0`.
- MUL/MULH/MULHSU/MULHU with op1=0xFFFFFFFF (−1) and op2=0x00000002:
  - MUL gives 0xFFFFFFFE.
  - MULH gives 0xFFFFFFFF.
  - MULHSU gives 0xFFFFFFFF.
  - MULHU gives 0x00000001.
  - For each, `hold_o` is high for exactly 32 cycles and the write occurs at N+33.
- DIV −7/2 gives 0xFFFFFFFD and REM −7/2 gives 0xFFFFFFFF. DIVU x/0 gives 0xFFFFFFFF and REMU 5/0 gives 5. DIV 0x80000000/−1 gives 0x80000000 and REM of the same gives 0. Latency is 33 in every case.
- Back-to-back: MUL, then ADD, then DIV with inputs changed mid-BUSY. Captured operands are used, exactly three write pulses occur in order, and the ADD retires at N+34.
- Unsupported opcode (e.g. 0x00000073) and an M op with `reg_wen_i=0`: no write pulse. The M op with `reg_wen_i=0` still holds for 32 cycles.
